// File: rtl/wrapper.sv
// DIP-to-LED bring-up wrapper: fixed load/store loop sequencer plus OLED, accelerometer and UART echo.
// Define WRAPPER_UART_ECHO_EN to build the UART echo channel; otherwise the UART outputs are tied to 0.
module wrapper #(
    parameter int N_LEDs_OUT  = 8,
    parameter int N_DIPs      = 16,
    parameter int N_PBs       = 3,
    parameter int LOOP_CYCLES = 32,
    parameter int STORE_STEP  = 16
) (
    input  logic [N_DIPs-1:0]     DIP,
    input  logic [N_PBs-1:0]      PB,
    output logic [N_LEDs_OUT-1:0] LED_OUT,
    output logic [6:0]            LED_PC,
    output logic [31:0]           SEVENSEGHEX,
    output logic [7:0]            UART_TX,
    input  logic                  UART_TX_ready,
    output logic                  UART_TX_valid,
    input  logic [7:0]            UART_RX,
    input  logic                  UART_RX_valid,
    output logic                  UART_RX_ack,
    output logic                  OLED_Write,
    output logic [6:0]            OLED_Col,
    output logic [5:0]            OLED_Row,
    output logic [23:0]           OLED_Data,
    input  logic [31:0]           ACCEL_Data,
    output logic                  ACCEL_DReady,
    input  logic                  RESET,
    input  logic                  CLK
);

    localparam int SW = $clog2(LOOP_CYCLES);
    localparam logic [SW-1:0] LAST_STEP = SW'(LOOP_CYCLES - 1);
    localparam logic [SW-1:0] STORE_AT  = SW'(STORE_STEP);

    logic [SW-1:0]     step;
    logic [N_DIPs-1:0] dip_reg;
    logic [31:0]       accel_reg;
    logic [6:0]        iter;
    logic [15:0]       dip16;
    logic              run;
    logic              at_load;
    logic              at_store;

    assign run      = ~PB[0];
    assign at_load  = run && (step == '0);
    assign at_store = run && (step == STORE_AT);
    assign dip16    = 16'(dip_reg);
    assign LED_PC   = 7'(step);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            step         <= '0;
            dip_reg      <= '0;
            accel_reg    <= '0;
            iter         <= '0;
            LED_OUT      <= '0;
            SEVENSEGHEX  <= '0;
            OLED_Write   <= 1'b0;
            OLED_Col     <= '0;
            OLED_Row     <= '0;
            OLED_Data    <= '0;
            ACCEL_DReady <= 1'b0;
        end else begin
            ACCEL_DReady <= at_load;
            OLED_Write   <= at_store;
            if (run) begin
                step <= (step == LAST_STEP) ? '0 : step + SW'(1);
            end
            if (at_load) begin
                dip_reg   <= DIP;
                accel_reg <= ACCEL_Data;
            end
            // Store sees dip_reg from this loop's load; DIP itself is never read here.
            if (at_store) begin
                LED_OUT     <= dip_reg[N_LEDs_OUT-1:0];
                SEVENSEGHEX <= PB[1] ? accel_reg : 32'(dip_reg);
                OLED_Row    <= dip16[13:8];
                OLED_Col    <= iter;
                OLED_Data   <= {dip16[7:0], dip16[15:8], 8'h00};
                iter        <= (iter == 7'd95) ? '0 : iter + 7'd1;
            end
        end
    end

`ifdef WRAPPER_UART_ECHO_EN
    typedef enum logic {
        UART_IDLE,
        UART_SEND
    } uart_state_t;

    uart_state_t uart_state;

    // One-deep echo buffer: accepting a byte blocks further acks until it has been sent.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            uart_state    <= UART_IDLE;
            UART_TX       <= '0;
            UART_TX_valid <= 1'b0;
            UART_RX_ack   <= 1'b0;
        end else begin
            UART_RX_ack <= 1'b0;
            case (uart_state)
                UART_IDLE: begin
                    if (UART_RX_valid) begin
                        UART_RX_ack   <= 1'b1;
                        UART_TX       <= UART_RX;
                        UART_TX_valid <= 1'b1;
                        uart_state    <= UART_SEND;
                    end
                end
                UART_SEND: begin
                    if (UART_TX_ready) begin
                        UART_TX_valid <= 1'b0;
                        uart_state    <= UART_IDLE;
                    end
                end
            endcase
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^PB;
`else
    assign UART_TX       = '0;
    assign UART_TX_valid = 1'b0;
    assign UART_RX_ack   = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{PB, UART_TX_ready, UART_RX, UART_RX_valid};
`endif

endmodule

// File: tb/tb_wrapper.sv
// Randomized and directed bench for wrapper, checked against a loop-position reference model.
module tb_wrapper;

    localparam int LOOP  = 32;
    localparam int STORE = 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] DIP;
    logic [2:0]  PB;
    logic [7:0]  LED_OUT;
    logic [6:0]  LED_PC;
    logic [31:0] SEVENSEGHEX;
    logic [7:0]  UART_TX;
    logic        UART_TX_ready;
    logic        UART_TX_valid;
    logic [7:0]  UART_RX;
    logic        UART_RX_valid;
    logic        UART_RX_ack;
    logic        OLED_Write;
    logic [6:0]  OLED_Col;
    logic [5:0]  OLED_Row;
    logic [23:0] OLED_Data;
    logic [31:0] ACCEL_Data;
    logic        ACCEL_DReady;

    always #5 CLK = ~CLK;

    wrapper #(
        .N_LEDs_OUT (8),
        .N_DIPs     (16),
        .N_PBs      (3),
        .LOOP_CYCLES(LOOP),
        .STORE_STEP (STORE)
    ) dut (
        .DIP          (DIP),
        .PB           (PB),
        .LED_OUT      (LED_OUT),
        .LED_PC       (LED_PC),
        .SEVENSEGHEX  (SEVENSEGHEX),
        .UART_TX      (UART_TX),
        .UART_TX_ready(UART_TX_ready),
        .UART_TX_valid(UART_TX_valid),
        .UART_RX      (UART_RX),
        .UART_RX_valid(UART_RX_valid),
        .UART_RX_ack  (UART_RX_ack),
        .OLED_Write   (OLED_Write),
        .OLED_Col     (OLED_Col),
        .OLED_Row     (OLED_Row),
        .OLED_Data    (OLED_Data),
        .ACCEL_Data   (ACCEL_Data),
        .ACCEL_DReady (ACCEL_DReady),
        .RESET        (RESET),
        .CLK          (CLK)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position in the loop plus the values the load/store program holds.
    int          m_cnt;
    int          m_iter;
    logic [15:0] m_dip;
    logic [31:0] m_accel;
    logic [31:0] m_seg;
    logic [7:0]  m_led;
    logic        m_write;
    logic        m_dready;
    logic [6:0]  m_col;
    logic [5:0]  m_row;
    logic [23:0] m_data;
    logic        m_busy;
    logic        m_ack;
    logic [7:0]  m_tx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_iter = 0; m_dip = '0; m_accel = '0; m_seg = '0; m_led = '0;
        m_write = 0; m_dready = 0; m_col = '0; m_row = '0; m_data = '0;
        m_busy = 0; m_ack = 0; m_tx = '0;
    endtask

    task automatic model_edge();
        m_write  = 0;
        m_dready = 0;
        if (!PB[0]) begin
            if (m_cnt == 0) begin
                m_dip    = DIP;
                m_accel  = ACCEL_Data;
                m_dready = 1;
            end
            if (m_cnt == STORE) begin
                m_led   = m_dip[7:0];
                m_seg   = PB[1] ? m_accel : {16'h0000, m_dip};
                m_write = 1;
                m_row   = m_dip[13:8];
                m_col   = 7'(m_iter);
                m_data  = {m_dip[7:0], m_dip[15:8], 8'h00};
                m_iter  = (m_iter + 1) % 96;
            end
            m_cnt = (m_cnt + 1) % LOOP;
        end
`ifdef WRAPPER_UART_ECHO_EN
        m_ack = 0;
        if (m_busy) begin
            if (UART_TX_ready) m_busy = 0;
        end else if (UART_RX_valid) begin
            m_ack  = 1;
            m_tx   = UART_RX;
            m_busy = 1;
        end
`endif
    endtask

    task automatic check_all();
        check("led_out", LED_OUT, m_led);
        check("led_pc", LED_PC, m_cnt);
        check("sevenseg", SEVENSEGHEX, m_seg);
        check("accel_dready", ACCEL_DReady, m_dready);
        check("oled_write", OLED_Write, m_write);
        check("oled_col", OLED_Col, m_col);
        check("oled_row", OLED_Row, m_row);
        check("oled_data", OLED_Data, m_data);
        check("uart_tx", UART_TX, m_tx);
        check("uart_tx_valid", UART_TX_valid, m_busy);
        check("uart_rx_ack", UART_RX_ack, m_ack);
    endtask

    // Inputs are stable when this is called and stay so through the next rising edge.
    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
        if (m_ack) UART_RX_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   pulses;
        int   acks;
        logic saw55;
        logic moved;
        logic [6:0] pc_hold;

        DIP = 16'hFFFF; PB = '0; ACCEL_Data = 32'hCAFE0001;
        UART_TX_ready = 0; UART_RX = '0; UART_RX_valid = 0;
        model_reset();
        #12;
        check_all();
        RESET = 1'b1;

        tick();
        check("first_load_dready", ACCEL_DReady, 1'b1);
        repeat (15) tick();
        check("led_pre_store", LED_OUT, 8'h00);
        tick();
        check("led_store_ff", LED_OUT, 8'hFF);
        check("seg_store_ffff", SEVENSEGHEX, 32'h0000FFFF);
        while (m_cnt != LOOP - 1) tick();
        check("pc_max", LED_PC, 7'd31);
        tick();
        check("pc_wrap", LED_PC, 7'd0);

        tick(); tick();
        DIP = 16'hAAAA;
        while (m_cnt != STORE + 1) tick();
        check("led_hold_ff", LED_OUT, 8'hFF);
        repeat (LOOP) tick();
        check("led_aa", LED_OUT, 8'hAA);

        while (m_cnt != 4) tick();
        DIP = 16'h5555;
        saw55 = 0;
        for (int i = 0; i < 76; i++) begin
            if (i == 12) DIP = 16'h0000;
            tick();
            if (LED_OUT == 8'h55) saw55 = 1;
        end
        check("never_55", saw55, 1'b0);
        check("led_00", LED_OUT, 8'h00);

        PB = 3'b001;
        pc_hold = LED_PC;
        pulses = 0;
        moved = 0;
        repeat (50) begin
            tick();
            pulses += 32'(OLED_Write) + 32'(ACCEL_DReady);
            if (LED_PC != pc_hold) moved = 1;
        end
        check("pause_pulses", pulses, 0);
        check("pause_pc_moved", moved, 1'b0);
        PB = 3'b010;
        ACCEL_Data = 32'h12345678;
        repeat (2 * LOOP) tick();
        check("seg_accel", SEVENSEGHEX, 32'h12345678);
        PB = '0;

`ifdef WRAPPER_UART_ECHO_EN
        UART_TX_ready = 0; UART_RX = 8'h41; UART_RX_valid = 1;
        acks = 0;
        repeat (5) begin tick(); acks += 32'(UART_RX_ack); end
        check("rx_ack_once", acks, 1);
        check("tx_41", UART_TX, 8'h41);
        check("tx_valid_held", UART_TX_valid, 1'b1);
        UART_RX = 8'h42; UART_RX_valid = 1;
        acks = 0;
        repeat (5) begin tick(); acks += 32'(UART_RX_ack); end
        check("second_ack_blocked", acks, 0);
        UART_TX_ready = 1;
        tick();
        check("ack_not_on_return", UART_RX_ack, 1'b0);
        UART_TX_ready = 0;
        acks = 0;
        repeat (3) begin tick(); acks += 32'(UART_RX_ack); end
        check("second_ack", acks, 1);
        check("tx_42", UART_TX, 8'h42);
        UART_TX_ready = 1;
        tick();
`else
        UART_TX_ready = 0; UART_RX = 8'h41; UART_RX_valid = 1;
        acks = 0;
        repeat (5) begin tick(); acks += 32'(UART_RX_ack); end
        check("no_echo_ack", acks, 0);
        check("no_echo_valid", UART_TX_valid, 1'b0);
        UART_RX_valid = 0;
`endif

        for (int i = 0; i < 3600; i++) begin
            if ($urandom_range(0, 7) == 0) DIP = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ACCEL_Data = $urandom;
            PB[0] = ($urandom_range(0, 15) == 0);
            PB[1] = 1'($urandom);
            PB[2] = 1'($urandom);
            if (!UART_RX_valid && $urandom_range(0, 3) == 0) begin
                UART_RX = 8'($urandom);
                UART_RX_valid = 1;
            end
            UART_TX_ready = 1'($urandom);
            tick();
        end

        PB = '0;
        while (m_cnt != 10) tick();
        #3 RESET = 1'b0;
        #1;
        model_reset();
        UART_RX_valid = 0;
        check_all();
        #2 RESET = 1'b1;
        tick();
        check("restart_dready", ACCEL_DReady, 1'b1);
        check("restart_pc", LED_PC, 7'd1);
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wrapper.md
Name: wrapper

Overview:
- Self-contained I/O wrapper for board-level bring-up; replaces the processor-plus-memory wrapper when running the DIP-to-LED demo flow.
- A fixed-function loop sequencer emulates a load/store program: it samples the DIP switches once per loop and later writes them to the LEDs and the seven-segment display.
- Also provides a UART echo channel, an OLED pixel writer and an accelerometer read strobe.
- Sits between the board top level and the physical peripheral drivers.

Parameters:
- N_LEDs_OUT, 8, LED output width (1..16).
- N_DIPs, 16, DIP switch width.
- N_PBs, 3, push-button width (at least 2).
- LOOP_CYCLES, 32, sequencer loop length in clocks (power of 2, 8..128).
- STORE_STEP, 16, loop step at which the store occurs (0 < STORE_STEP < LOOP_CYCLES).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (asserted when 0).
- DIP  in  N_DIPs  switch inputs.
- PB  in  N_PBs  push buttons; PB[0] pauses the sequencer, PB[1] selects the accelerometer display.
- LED_OUT  out  N_LEDs_OUT  LED outputs.
- LED_PC  out  7  current sequencer step.
- SEVENSEGHEX  out  32  value for the 8-digit hex display.
- UART_TX  out  8  transmit byte.
- UART_TX_ready  in  1  downstream can accept a byte.
- UART_TX_valid  out  1  UART_TX holds a valid byte.
- UART_RX  in  8  received byte.
- UART_RX_valid  in  1  UART_RX holds a valid byte.
- UART_RX_ack  out  1  one-cycle acknowledge of UART_RX.
- OLED_Write  out  1  one-cycle pixel write strobe.
- OLED_Col  out  7  pixel column, 0..95.
- OLED_Row  out  6  pixel row.
- OLED_Data  out  24  pixel RGB value.
- ACCEL_Data  in  32  accelerometer sample.
- ACCEL_DReady  out  1  one-cycle accelerometer read strobe.
- Instantiation order is positional: DIP, PB, LED_OUT, LED_PC, SEVENSEGHEX, UART_TX, UART_TX_ready, UART_TX_valid, UART_RX, UART_RX_valid, UART_RX_ack, OLED_Write, OLED_Col, OLED_Row, OLED_Data, ACCEL_Data, ACCEL_DReady, RESET, CLK.

Behaviour:
- Reset (RESET=0, asynchronous) clears all registers and outputs to 0, including step, dip_reg, iteration count, UART state and all strobes.
- Step counter:
  - Advances by 1 on every rising clock edge while PB[0]=0, wrapping from LOOP_CYCLES-1 to 0.
  - PB[0]=1 freezes the step counter; no load or store strobes occur while frozen.
  - LED_PC = step zero-extended or truncated to 7 bits.
- Load (edge where step==0):
  - dip_reg <= DIP.
  - ACCEL_DReady pulses high for that one cycle.
  - accel_reg <= ACCEL_Data on the same edge.
  - The first load occurs on the first rising edge after reset release.
  - DIP values that change and revert entirely between two load edges are never observed.
- Store (edge where step==STORE_STEP):
  - LED_OUT <= dip_reg[N_LEDs_OUT-1:0].
  - SEVENSEGHEX <= PB[1] ? accel_reg : zero-extended dip_reg.
  - OLED_Write pulses for one cycle.
  - OLED_Row = dip_reg[13:8] mod 64.
  - OLED_Col = iteration count, incremented after each store, wrapping from 95 to 0.
  - OLED_Data = {dip_reg[7:0], dip_reg[15:8], 8'h00}.
  - Load-to-LED latency is STORE_STEP cycles; DIP-to-LED worst case is LOOP_CYCLES+STORE_STEP.
- UART echo (one-deep buffer, two states):
  - IDLE: if UART_RX_valid=1, pulse UART_RX_ack for one cycle, latch UART_RX into UART_TX, go to SEND.
  - SEND: UART_TX_valid=1 and UART_TX held stable. On a cycle with UART_TX_ready=1, drop valid and return to IDLE.
  - No RX acknowledge is issued in SEND.
  - A new RX byte is acknowledged no earlier than the cycle after return to IDLE.
  - RX data is never lost; the source must hold valid until acknowledged.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro WRAPPER_UART_ECHO_EN.
- Defined: UART echo as specified above.
- Undefined: UART_TX=0, UART_TX_valid=0 and UART_RX_ack=0 permanently; the echo FSM is not synthesized.

Test Plan:
- Reset then DIP=16'hFFFF: ACCEL_DReady pulse on first edge; LED_OUT=8'hFF and SEVENSEGHEX=32'h0000FFFF exactly 16 cycles later; LED_PC counts 0..31 and wraps.
- DIP=16'hAAAA set 2 cycles after a load: LED_OUT stays 8'hFF until the next loop's store, then becomes 8'hAA.
- DIP=16'h5555 held 12 cycles strictly between two loads, then 16'h0000: LED_OUT never shows 8'h55; later shows 8'h00.
- Hold PB[0]=1 for 50 cycles: LED_PC constant and no OLED_Write or ACCEL_DReady pulses. PB[1]=1 with ACCEL_Data=32'h12345678: SEVENSEGHEX=32'h12345678 after the next store.
- UART_RX=8'h41 valid with UART_TX_ready=0 for 5 cycles: one ack pulse; UART_TX=8'h41 with valid held. A second RX byte is not acknowledged until ready=1 completes the transfer.
- Assert RESET=0 mid-loop, between clock edges: all outputs go to 0 immediately; the sequence restarts from step 0 after release.
